pc_sequencer: RTL
=================

Name: pc_sequencer

Overview:
- Owns the program counter register of the single-cycle RV32 core and sequences instruction fetch against an instruction memory that can insert wait states.
- Selects the next PC from three sources: sequential (PC+4), branch target, or JALR target.
- Honours pipeline stall and halt requests, and detects a fetch timeout.
- Sits between the control/branch unit and the instruction memory port; the core's PC+4 adder consumes pc_data.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- TRAP_VECTOR, 32'h0000_0100, PC loaded on a misaligned redirect (only when the optional feature is enabled).
- MAX_WAIT, 8, fetch cycles without imem_ready before a timeout (range 2..15).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hold the current PC and suppress retire.
- branch_taken  in  1  conditional branch or JAL redirect this cycle.
- branch_target  in  32  redirect address for a branch or JAL.
- jalr_en  in  1  JALR redirect this cycle.
- jalr_target  in  32  raw JALR sum (rs1+imm).
- halt_req  in  1  stop after the current instruction retires.
- imem_ready  in  1  instruction memory has data for pc_data.
- imem_req  out  1  fetch request for address pc_data.
- pc_data  out  32  current PC (registered).
- next_pc  out  32  selected next PC (combinational).
- instr_valid  out  1  instruction retires this cycle.
- fetch_err  out  1  sticky fetch-timeout flag.
- halted  out  1  sequencer halted.
- misalign  out  1  one-cycle pulse when a misaligned redirect is trapped.

Behaviour:
- Clock and reset: single clock clk; rst is synchronous, active-high.

- Reset values (on the rst edge):
  - pc_data=RESET_VECTOR
  - state=S_BOOT
  - imem_req=0, instr_valid=0, fetch_err=0, halted=0, misalign=0
  - wait counter=0
  - rst wins over every other input, including mid-fetch or while in S_HALT; an outstanding fetch is abandoned.

- States:
  - S_BOOT: imem_req=0; goes unconditionally to S_FETCH on the next cycle (one idle cycle after reset).
  - S_FETCH: imem_req=1.
    - Retire condition: imem_ready=1 and stall=0. instr_valid=1 combinationally that cycle; pc_data<=next_pc at the edge; wait counter clears.
    - imem_ready=1 with stall=1: no retire. PC holds, instr_valid=0, wait counter clears.
    - imem_ready=0: wait counter increments. When the counter reaches MAX_WAIT-1 with imem_ready still 0, set fetch_err=1 and go to S_HALT. The PC is not updated.
    - halt_req sampled on a retire cycle: PC updates normally, then the next state is S_HALT. halt_req on a non-retire cycle is ignored.
  - S_HALT: imem_req=0, halted=1, instr_valid=0, PC frozen. Left only by rst.

- next_pc selection (priority order):
  1. jalr_en: {jalr_target[31:1],1'b0}
  2. branch_taken: branch_target
  3. otherwise: pc_data+32'd4, modulo 2^32 (32'hFFFF_FFFC wraps to 32'h0000_0000)
  - Redirect inputs are ignored unless the cycle retires.

- Timing:
  - PC update latency is 1 cycle from the retire edge.
  - With zero-wait memory (imem_ready tied 1, no stall) one instruction retires per cycle.

- fetch_err: sticky until rst.

Optional Feature:
- Macro: MISALIGN_TRAP_EN
- Defined: if the selected redirect target has bits [1:0]!=2'b00 on a retire cycle, next_pc=TRAP_VECTOR and misalign pulses 1 for that cycle. Sequential PC+4 never traps.
- Undefined: next_pc[1:0] is forced to 2'b00 (silent truncation) and misalign is tied 0.

Test Plan:
- Reset, then imem_ready=1, no stall: pc_data goes 0x0 (boot cycle), 0x0, 0x4, 0x8, 0xC on consecutive edges; instr_valid high from the first S_FETCH cycle.
- At PC=0x8, branch_taken=1 and jalr_en=1 together, branch_target=0x40, jalr_target=0x81: next PC=0x80 (JALR wins, LSB cleared).
- stall=1 for 3 cycles at PC=0x10 with imem_ready=1: PC holds 0x10, instr_valid=0; resumes to 0x14 after stall drops.
- imem_ready held 0 at MAX_WAIT=8: fetch_err=1, halted=1 after 8 S_FETCH cycles; PC unchanged; cleared only by rst.
- halt_req=1 on retire at PC=0x20: PC becomes 0x24, halted=1 the following cycle, imem_req=0; assert rst: pc_data=RESET_VECTOR, halted=0.
- MISALIGN_TRAP_EN defined, branch_target=0x42 taken: PC=0x100, misalign pulses 1 cycle. Undefined: PC=0x40, misalign stays 0.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer
// Owns the RV32 program counter and sequences instruction fetch against an
// instruction memory that may insert wait states. Selects the next PC from
// PC+4, a branch/JAL target or a JALR target, honours stall and halt requests,
// and flags a fetch timeout.
//
// Optional feature: define MISALIGN_TRAP_EN to redirect misaligned branch/JALR
// targets to TRAP_VECTOR with a one-cycle misalign pulse. Without it, the low
// two bits of next_pc are silently cleared and misalign is held at 0.
//
// Ports:
//   clk           system clock, rising edge
//   rst           synchronous active-high reset
//   stall         hold the current PC and suppress retire
//   branch_taken  branch/JAL redirect this cycle
//   branch_target branch/JAL redirect address
//   jalr_en       JALR redirect this cycle
//   jalr_target   raw JALR sum (rs1+imm)
//   halt_req      stop after the current instruction retires
//   imem_ready    instruction memory has data for pc_data
//   imem_req      fetch request for address pc_data
//   pc_data       current PC (registered)
//   next_pc       selected next PC (combinational)
//   instr_valid   instruction retires this cycle
//   fetch_err     sticky fetch-timeout flag
//   halted        sequencer halted
//   misalign      one-cycle pulse when a misaligned redirect is trapped
//
// state   | meaning
// S_BOOT  | idle cycle after reset, no fetch
// S_FETCH | fetching pc_data, retire when imem_ready and not stalled
// S_HALT  | frozen after halt_req or fetch timeout, left only by rst
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100,
  parameter int unsigned MAX_WAIT     = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jalr_en,
  input  logic [31:0] jalr_target,
  input  logic        halt_req,
  input  logic        imem_ready,
  output logic        imem_req,
  output logic [31:0] pc_data,
  output logic [31:0] next_pc,
  output logic        instr_valid,
  output logic        fetch_err,
  output logic        halted,
  output logic        misalign
);

  typedef enum logic [1:0] {S_BOOT, S_FETCH, S_HALT} state_t;

  localparam logic [3:0] WAIT_LAST = 4'(MAX_WAIT - 1);

  state_t      state, state_nxt;
  logic [31:0] pc_q;
  logic [3:0]  wait_cnt;
  logic        fetch_err_q;
  logic        retire;
  logic        timeout;
  logic        redirect;
  logic [31:0] redirect_target;
  logic [31:0] seq_pc;

  assign pc_data   = pc_q;
  assign fetch_err = fetch_err_q;

  assign retire  = (state == S_FETCH) && imem_ready && !stall;
  assign timeout = (state == S_FETCH) && !imem_ready && (wait_cnt == WAIT_LAST);

  // JALR clears bit 0 of the raw sum before selection.
  always_comb begin
    seq_pc          = pc_q + 32'd4;
    redirect        = jalr_en || branch_taken;
    redirect_target = jalr_en ? {jalr_target[31:1], 1'b0} : branch_target;
  end

`ifdef MISALIGN_TRAP_EN
  logic unused_jalr_lsb;
  assign unused_jalr_lsb = jalr_target[0];

  always_comb begin
    next_pc  = seq_pc;
    misalign = 1'b0;
    if (redirect) begin
      if (retire && (redirect_target[1:0] != 2'b00)) begin
        next_pc  = TRAP_VECTOR;
        misalign = 1'b1;
      end else begin
        next_pc = redirect_target;
      end
    end
  end
`else
  logic unused_inputs;
  assign unused_inputs = jalr_target[0] ^ (^TRAP_VECTOR);

  always_comb begin
    next_pc  = redirect ? {redirect_target[31:2], 2'b00} : {seq_pc[31:2], 2'b00};
    misalign = 1'b0;
  end
`endif

  always_comb begin
    state_nxt   = state;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    halted      = 1'b0;
    case (state)
      S_BOOT: state_nxt = S_FETCH;
      S_FETCH: begin
        imem_req    = 1'b1;
        instr_valid = retire;
        if ((retire && halt_req) || timeout) state_nxt = S_HALT;
      end
      S_HALT: halted = 1'b1;
      default: state_nxt = S_BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_BOOT;
      pc_q        <= RESET_VECTOR;
      wait_cnt    <= 4'd0;
      fetch_err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (retire) pc_q <= next_pc;
      if (state == S_FETCH) begin
        if (imem_ready)    wait_cnt <= 4'd0;
        else if (!timeout) wait_cnt <= wait_cnt + 4'd1;
      end
      if (timeout) fetch_err_q <= 1'b1;
    end
  end

endmodule
